number_entry_unit: RTL
======================

# number_entry_unit

Parametrised operand register for the calculator controller. It holds the number currently being entered or displayed. It accepts keypad digits, backspace, sign toggle, clear, commit and load-from-datapath commands over a valid/ready handshake. Unlike a plain load register, it builds the two's-complement value incrementally (×10 + digit), enforces digit-count and range limits, and removes digits with a multicycle divide-by-10. It sits between the controller state machine and the ALU/data-stack operand path.

## Interface
Parameters:
- WIDTH, 32, width of number_Q in bits (two's complement); minimum 5
- MAX_DIGITS, 9, maximum decimal digits accepted in one entry

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid & ready; equals ~busy
- cmd_op  in  3  NOP, CLEAR, DIGIT, BACK, NEG, LOAD, COMMIT (shared encodings)
- cmd_digit  in  4  digit value for DIGIT
- load_data  in  WIDTH  value for LOAD (ALU result or stack top, selected upstream)
- number_Q  out  WIDTH  current value, two's complement
- digit_count  out  $clog2(MAX_DIGITS+1)  digits in the current entry
- entering  out  1  entry in progress
- overflow  out  1  sticky reject flag
- busy  out  1  divider running

## Operation
- Internal state: mag (WIDTH bits, unsigned), sign, digit_count, entering, overflow, FSM {IDLE, DIV}.
- number_Q = sign ? -mag : mag, truncated to WIDTH.
- Range limit: LIM = 2^(WIDTH-1)-1.
- Reset: all outputs 0; FSM to IDLE. A reset during DIV aborts the division and discards its result.
- CLEAR: mag, sign, digit_count, entering and overflow all go to 0.
- DIGIT, when entering=0: first zero mag, sign and digit_count, then set entering=1 and apply the digit.
- DIGIT handling:
  - cmd_digit > 9: ignored; the command is still accepted.
  - digit_count == MAX_DIGITS, or mag*10 + d > LIM: rejected; overflow set; value unchanged.
  - mag == 0 and d == 0: leading zero; count stays 0.
  - Otherwise: mag <= mag*10 + d, computed as (mag<<3)+(mag<<1)+d on WIDTH+4 bits; digit_count increments.
- BACK:
  - digit_count == 0 or entering == 0: no-op.
  - Otherwise: go to DIV. On completion mag <= mag/10 and digit_count decrements. If mag becomes 0, sign clears.
- NEG:
  - mag == 0: no-op (no negative zero).
  - sign == 1 and mag > LIM: rejected; overflow set.
  - Otherwise: sign toggles.
- LOAD: sign = load_data[WIDTH-1]; mag = |load_data| (2^(WIDTH-1) is allowed); entering = 0; digit_count = 0; overflow = 0.
- COMMIT: entering = 0; value held.
- NOP: accepted, no effect.
- overflow clears only on CLEAR, LOAD or Reset.

## Timing
- All non-BACK commands: single cycle; result visible in the cycle after the accepting edge.
- BACK that divides: busy goes high after the accepting edge and stays high for exactly WIDTH cycles. The quotient appears on number_Q in the first cycle with busy low.
- cmd_ready is low while busy. Commands presented during DIV are held off, never dropped.
- cmd_ready has no combinational path from cmd_valid.

## Configuration
- NUMBER_ENTRY_BACKSPACE_EN defined: divider instantiated; BACK behaves as described above.
- Not defined: no divider and no DIV state; BACK is a single-cycle no-op; busy is tied to 0.

## Structure
- Shared include (controller internal header):
  - NE_OP_* command encodings
  - NE_DIGIT_MAX = 9
- Sub-module number_div10: sequential restoring divider by the constant 10.
  - Ports: start, dividend[WIDTH], quotient[WIDTH], done; WIDTH iterations.
  - Same Clock/Reset as the parent.

## Test plan
- WIDTH=8, MAX_DIGITS=3; CLEAR, then DIGIT 1, 2, 7 -> number_Q=127, digit_count=3; DIGIT 5 -> rejected, overflow=1, number_Q=127.
- DIGIT 1, 2, 8 -> third digit rejected (128 > 127), number_Q=12, overflow=1; CLEAR -> overflow=0.
- DIGIT 4, 5, NEG -> number_Q=-45 (8'hD3); BACK -> busy high for 8 cycles, then number_Q=-4 and digit_count=1; BACK -> number_Q=0, sign cleared.
- LOAD 8'h80 -> number_Q=-128, entering=0; NEG -> rejected, overflow=1; DIGIT 3 -> fresh entry, number_Q=3, overflow still 1.
- DIGIT 0, 0, 7 -> number_Q=7, digit_count=1; DIGIT 12 -> accepted, no change.
- Assert Reset midway through a BACK division -> all outputs 0, busy=0, cmd_ready=1; with NUMBER_ENTRY_BACKSPACE_EN undefined, BACK never raises busy.

Source files
------------

// File: rtl/number_entry_unit_pkg.sv
// Shared command encodings and small helpers for the calculator number-entry unit.
package number_entry_unit_pkg;

  typedef enum logic [2:0] {
    NE_OP_NOP    = 3'd0,
    NE_OP_CLEAR  = 3'd1,
    NE_OP_DIGIT  = 3'd2,
    NE_OP_BACK   = 3'd3,
    NE_OP_NEG    = 3'd4,
    NE_OP_LOAD   = 3'd5,
    NE_OP_COMMIT = 3'd6
  } ne_op_e;

  localparam logic [3:0] NE_DIGIT_MAX = 4'd9;

  function automatic logic ne_is_digit(input logic [3:0] d);
    return (d <= NE_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/number_entry_unit_div10.sv
// Sequential restoring divider by the constant 10; one quotient bit per cycle,
// WIDTH iterations in total (the first is taken on the start edge).
module number_div10 #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic             done_o
);

  localparam int NW = $clog2(WIDTH + 1);

  logic [3:0]       rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [NW-1:0]    cnt_q;
  logic             run_q, done_q;
  logic [3:0]       src_rem_s;
  logic [WIDTH-1:0] src_quo_s;
  logic [4:0]       trial_s, diff_s;

  // One restoring step: shift the next dividend bit into the remainder, subtract 10 if it fits.
  always_comb begin
    src_rem_s = start_i ? 4'd0 : rem_q;
    src_quo_s = start_i ? dividend_i : quo_q;
    trial_s   = {src_rem_s, src_quo_s[WIDTH-1]};
    diff_s    = trial_s - 5'd10;
    if (trial_s >= 5'd10) begin
      rem_d = diff_s[3:0];
      quo_d = {src_quo_s[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = trial_s[3:0];
      quo_d = {src_quo_s[WIDTH-2:0], 1'b0};
    end
  end

  // Iteration counter and done pulse; done is registered one cycle after the last step.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= 4'd0;
      quo_q  <= {WIDTH{1'b0}};
      cnt_q  <= {NW{1'b0}};
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= NW'(WIDTH - 1);
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q - NW'(1);
      run_q  <= (cnt_q != NW'(1));
      done_q <= (cnt_q == NW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = done_q;

endmodule

// File: rtl/number_entry_unit.sv
// Operand register that builds a signed decimal entry digit by digit.
// Optional backspace divider enabled by defining NUMBER_ENTRY_BACKSPACE_EN.
module number_entry_unit
  import number_entry_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 9
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [2:0]                      cmd_op_i,
  input  logic [3:0]                      cmd_digit_i,
  input  logic [WIDTH-1:0]                load_data_i,
  output logic [WIDTH-1:0]                number_q_o,
  output logic [$clog2(MAX_DIGITS+1)-1:0] digit_count_o,
  output logic                            entering_o,
  output logic                            overflow_o,
  output logic                            busy_o
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [WIDTH+3:0] LIM = {5'b00000, {(WIDTH-1){1'b1}}};

  logic [WIDTH-1:0] mag_q, mag_d, num_q, num_d;
  logic             sign_q, sign_d, ent_q, ent_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_s;
  logic [WIDTH-1:0] base_mag_s;
  logic             base_sign_s;
  logic [CW-1:0]    base_cnt_s;
  logic [WIDTH+3:0] prod_s;

`ifdef NUMBER_ENTRY_BACKSPACE_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DIV  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             div_start_s, div_done_s;
  logic [WIDTH-1:0] div_quo_s;

  number_div10 #(.WIDTH(WIDTH)) u_div10 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start_s),
    .dividend_i (mag_q),
    .quotient_o (div_quo_s),
    .done_o     (div_done_s)
  );

  assign busy_s = (state_q == ST_DIV);
`else
  assign busy_s = 1'b0;
`endif

  // Command decode and next-state computation.
  always_comb begin
    mag_d  = mag_q;
    sign_d = sign_q;
    cnt_d  = cnt_q;
    ent_d  = ent_q;
    ovf_d  = ovf_q;
`ifdef NUMBER_ENTRY_BACKSPACE_EN
    state_d     = state_q;
    div_start_s = 1'b0;
`endif
    // A digit after a commit or load starts a fresh positive entry.
    base_mag_s  = ent_q ? mag_q : {WIDTH{1'b0}};
    base_sign_s = ent_q & sign_q;
    base_cnt_s  = ent_q ? cnt_q : {CW{1'b0}};
    prod_s = ({4'b0000, base_mag_s} << 3) + ({4'b0000, base_mag_s} << 1)
           + {{WIDTH{1'b0}}, cmd_digit_i};

    if (busy_s) begin
`ifdef NUMBER_ENTRY_BACKSPACE_EN
      if (div_done_s) begin
        mag_d   = div_quo_s;
        cnt_d   = cnt_q - CW'(1);
        sign_d  = (div_quo_s == {WIDTH{1'b0}}) ? 1'b0 : sign_q;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_DIV;
      end
`endif
    end else if (cmd_valid_i) begin
      case (ne_op_e'(cmd_op_i))
        NE_OP_CLEAR: begin
          mag_d  = {WIDTH{1'b0}};
          sign_d = 1'b0;
          cnt_d  = {CW{1'b0}};
          ent_d  = 1'b0;
          ovf_d  = 1'b0;
        end
        NE_OP_DIGIT: begin
          if (ne_is_digit(cmd_digit_i)) begin
            mag_d  = base_mag_s;
            sign_d = base_sign_s;
            cnt_d  = base_cnt_s;
            ent_d  = 1'b1;
            if ((base_cnt_s == CW'(MAX_DIGITS)) || (prod_s > LIM)) begin
              ovf_d = 1'b1;
            end else if ((base_mag_s == {WIDTH{1'b0}}) && (cmd_digit_i == 4'd0)) begin
              cnt_d = base_cnt_s;
            end else begin
              mag_d = prod_s[WIDTH-1:0];
              cnt_d = base_cnt_s + CW'(1);
            end
          end else begin
            mag_d = mag_q;
          end
        end
        NE_OP_BACK: begin
`ifdef NUMBER_ENTRY_BACKSPACE_EN
          if ((cnt_q != {CW{1'b0}}) && ent_q) begin
            div_start_s = 1'b1;
            state_d     = ST_DIV;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end
        NE_OP_NEG: begin
          if (mag_q == {WIDTH{1'b0}}) begin
            sign_d = sign_q;
          end else if (sign_q && ({4'b0000, mag_q} > LIM)) begin
            ovf_d = 1'b1;
          end else begin
            sign_d = ~sign_q;
          end
        end
        NE_OP_LOAD: begin
          sign_d = load_data_i[WIDTH-1];
          mag_d  = load_data_i[WIDTH-1] ? (~load_data_i + {{(WIDTH-1){1'b0}}, 1'b1})
                                        : load_data_i;
          cnt_d  = {CW{1'b0}};
          ent_d  = 1'b0;
          ovf_d  = 1'b0;
        end
        NE_OP_COMMIT: ent_d = 1'b0;
        default:      ent_d = ent_q;
      endcase
    end else begin
      ent_d = ent_q;
    end

    num_d = sign_d ? (~mag_d + {{(WIDTH-1){1'b0}}, 1'b1}) : mag_d;
  end

  // State registers; the visible value is registered alongside its magnitude.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mag_q  <= {WIDTH{1'b0}};
      num_q  <= {WIDTH{1'b0}};
      sign_q <= 1'b0;
      cnt_q  <= {CW{1'b0}};
      ent_q  <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef NUMBER_ENTRY_BACKSPACE_EN
      state_q <= ST_IDLE;
`endif
    end else begin
      mag_q  <= mag_d;
      num_q  <= num_d;
      sign_q <= sign_d;
      cnt_q  <= cnt_d;
      ent_q  <= ent_d;
      ovf_q  <= ovf_d;
`ifdef NUMBER_ENTRY_BACKSPACE_EN
      state_q <= state_d;
`endif
    end
  end

  assign cmd_ready_o   = ~busy_s;
  assign busy_o        = busy_s;
  assign number_q_o    = num_q;
  assign digit_count_o = cnt_q;
  assign entering_o    = ent_q;
  assign overflow_o    = ovf_q;

endmodule
